pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Frame-rate game controller for the Pong display path. It owns all sprite positions, ball direction, scores and game phase, and advances them once per video frame on a pulse from the VGA timing generator. The renderer only reads the position and score outputs to draw each frame; it never moves sprites itself.

## Interface
- H_VIS, 640: visible width in pixels
- V_VIS, 480: visible height in pixels
- BALL_SIZE, 20: ball sprite edge in pixels; position is the top-left corner
- PAD_W, 15; PAD_H, 80: paddle width and height
- PAD_L_X, 0; PAD_R_X, 625: paddle left-edge x positions
- WALL_H, 6: top and bottom wall thickness
- PAD_STEP, 4: paddle pixels moved per frame
- BALL_STEP, 1: ball pixels moved per frame, per axis
- SERVE_FRAMES, 60: frames the ball holds at centre before play starts
- WIN_SCORE, 9: score that ends the game
- Clock  in  1  system clock; every register is on its rising edge
- Reset_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse driven by the timing generator at the start of vertical blanking
- start  in  1  one-cycle pulse; begins a game
- up_l, dn_l, up_r, dn_r  in  1 each  paddle buttons, already synchronised and active-high
- ball_x, ball_y  out  10 each  ball top-left position
- pad_l_y, pad_r_y  out  10 each  paddle top y positions
- score_l, score_r  out  4 each  scores
- ball_visible  out  1  high in SERVE and PLAY
- game_over  out  1  high in GAME_OVER

## Operation
- States: IDLE, SERVE, PLAY, POINT, GAME_OVER.
- IDLE:
  - start clears both scores, centres the ball at (310,230), sets x_dir=right and y_dir=down, loads the serve counter with SERVE_FRAMES, and goes to SERVE.
- SERVE:
  - Each frame_tick decrements the serve counter.
  - On the tick that makes the counter 0, go to PLAY.
- PLAY, on each frame_tick, in this order:
  1. **Top wall.** If y_dir=up and ball_y ≤ WALL_H+BALL_STEP, set y_dir=down.
  2. **Bottom wall.** If y_dir=down and ball_y+BALL_SIZE ≥ V_VIS−WALL_H−BALL_STEP, set y_dir=up.
  3. **Left side** (x_dir=left):
     - Hit: ball_x ≤ PAD_L_X+PAD_W and the rows overlap (ball_y+BALL_SIZE > pad_l_y and ball_y < pad_l_y+PAD_H). Set x_dir=right.
     - Miss: no hit and ball_x < BALL_STEP. Go to POINT with scorer=right.
  4. **Right side** (x_dir=right): mirror of step 3. Hit when ball_x+BALL_SIZE ≥ PAD_R_X with row overlap. Miss when ball_x ≥ H_VIS−BALL_SIZE. A miss gives scorer=left.
  5. **Move.** If no miss occurred, move the ball by BALL_STEP along the updated directions.
- POINT (lasts one clock):
  - Increment the scorer's score.
  - If the new score equals WIN_SCORE, go to GAME_OVER.
  - Otherwise centre the ball, set x_dir toward the player who conceded, keep y_dir, reload the serve counter, and go to SERVE.
- GAME_OVER: positions and scores hold. start behaves exactly as in IDLE.
- Paddles (SERVE and PLAY, on each frame_tick):
  - up alone: y −= PAD_STEP, saturating at WALL_H.
  - dn alone: y += PAD_STEP, saturating at V_VIS−WALL_H−PAD_H (394).
  - Both or neither pressed: no change.
- start is ignored in SERVE, PLAY and POINT.
- All arithmetic uses 10-bit unsigned values. Comparisons are arranged so no subtraction can underflow (move terms to the other side of the comparison).

## Timing
- Reset values:
  - state IDLE
  - ball (310,230), x_dir right, y_dir down
  - pad_l_y = pad_r_y = 200
  - scores 0
  - ball_visible 0, game_over 0
- Reset_n low at any point, including mid-frame or in POINT, forces these values immediately.
- All outputs are registered.
- Position updates appear on the outputs in the cycle after frame_tick, so they are stable before the first visible line.
- start takes effect in the cycle after its pulse.
- frame_tick arriving in the same cycle as start: start has priority and that tick is discarded.
- POINT → SERVE takes one clock. The next frame_tick is the first serve decrement.

## Structure
- Package pong_pkg holds:
  - the state enum
  - geometry defaults (H_VIS, V_VIS, BALL_SIZE, PAD_*, WALL_H), shared with the renderer so drawn and simulated geometry match
- Sub-module paddle_mover (saturating up/down register with frame enable), instantiated once per paddle.

## Test plan
- Reset, then start, then 60 ticks → ball_visible=1, state PLAY. The next tick moves the ball to (311,231).
- Ball at (320,455), y_dir down, one tick → y_dir up, ball_y=454.
- Ball at x=15, y=210, x_dir left, pad_l_y=200, one tick → x_dir right, ball_x=16. Scores unchanged.
- Ball at x=0, pad_l_y=394, x_dir left, tick → score_r +1, ball (310,230), x_dir left, then SERVE.
- score_l=8 and the left player scores → score_l=9, game_over=1. Further ticks do not change any output. A later start → scores 0, SERVE.
- up_l and dn_l held together for 10 ticks → pad_l_y unchanged. up_l alone for 60 ticks → pad_l_y saturates at 6. Reset_n pulsed mid-PLAY → every output returns to its reset value at once.

Source files
------------

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong states and playfield geometry
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_GAME_OVER
  } state_e;

  // Geometry is shared with the renderer so drawn and simulated sprites agree
  localparam logic [9:0] H_VIS     = 10'd640;
  localparam logic [9:0] V_VIS     = 10'd480;
  localparam logic [9:0] BALL_SIZE = 10'd20;
  localparam logic [9:0] PAD_W     = 10'd15;
  localparam logic [9:0] PAD_H     = 10'd80;
  localparam logic [9:0] PAD_L_X   = 10'd0;
  localparam logic [9:0] PAD_R_X   = 10'd625;
  localparam logic [9:0] WALL_H    = 10'd6;
  localparam logic [9:0] PAD_STEP  = 10'd4;
  localparam logic [9:0] BALL_STEP = 10'd1;

  localparam logic [9:0] BALL_X0   = 10'd310;
  localparam logic [9:0] BALL_Y0   = 10'd230;
  localparam logic [9:0] PAD_Y0    = 10'd200;
  localparam logic [9:0] PAD_Y_MAX = V_VIS - WALL_H - PAD_H;

  localparam logic [5:0] SERVE_FRAMES = 6'd60;
  localparam logic [3:0] WIN_SCORE    = 4'd9;

endpackage

// File: rtl/pong_game_ctrl_paddle_mover.sv
// rtl/pong_game_ctrl_paddle_mover.sv - saturating paddle position register
module paddle_mover
  import pong_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       up_i,
  input  logic       dn_i,
  output logic [9:0] y_o
);

  logic [9:0] y_q, y_d;

  // One step per enabled frame; both or neither button pressed holds position
  always_comb begin
    y_d = y_q;
    if (en_i && up_i && !dn_i) begin
      y_d = (y_q <= WALL_H + PAD_STEP) ? WALL_H : y_q - PAD_STEP;
    end else if (en_i && dn_i && !up_i) begin
      y_d = (y_q + PAD_STEP >= PAD_Y_MAX) ? PAD_Y_MAX : y_q + PAD_STEP;
    end
  end

  // Position register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) y_q <= PAD_Y0;
    else         y_q <= y_d;
  end

  assign y_o = y_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - frame-rate Pong game state, ball and score controller
module pong_game_ctrl
  import pong_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_tick_i,
  input  logic       start_i,
  input  logic       up_l_i,
  input  logic       dn_l_i,
  input  logic       up_r_i,
  input  logic       dn_r_i,
  output logic [9:0] ball_x_o,
  output logic [9:0] ball_y_o,
  output logic [9:0] pad_l_y_o,
  output logic [9:0] pad_r_y_o,
  output logic [3:0] score_l_o,
  output logic [3:0] score_r_o,
  output logic       ball_visible_o,
  output logic       game_over_o
);

  state_e     state_q;
  logic [9:0] ball_x_q, ball_y_q;
  logic       x_dir_q;      // 1 = right
  logic       y_dir_q;      // 1 = down
  logic [5:0] serve_cnt_q;
  logic       scorer_r_q;   // 1 = right player scored the pending point
  logic [3:0] score_l_q, score_r_q;
  logic       visible_q, game_over_q;

  logic       pad_en;
  logic [9:0] pad_l_y, pad_r_y;
  logic       hit_l, hit_r, miss, miss_r_scores;
  logic       x_dir_d, y_dir_d;
  logic [9:0] ball_x_d, ball_y_d;
  logic [3:0] score_inc;

  assign pad_en = frame_tick_i && ((state_q == ST_SERVE) || (state_q == ST_PLAY));

  paddle_mover u_pad_l (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (pad_en),
    .up_i   (up_l_i),
    .dn_i   (dn_l_i),
    .y_o    (pad_l_y)
  );

  paddle_mover u_pad_r (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (pad_en),
    .up_i   (up_r_i),
    .dn_i   (dn_r_i),
    .y_o    (pad_r_y)
  );

  // Wall bounce, paddle hit and miss detection in frame order; terms are kept unsubtracted
  always_comb begin
    y_dir_d = y_dir_q;
    if (!y_dir_d && (ball_y_q <= WALL_H + BALL_STEP)) y_dir_d = 1'b1;
    if (y_dir_d && (ball_y_q + BALL_SIZE >= V_VIS - WALL_H - BALL_STEP)) y_dir_d = 1'b0;

    hit_l = (ball_x_q <= PAD_L_X + PAD_W) &&
            (ball_y_q + BALL_SIZE > pad_l_y) && (ball_y_q < pad_l_y + PAD_H);
    hit_r = (ball_x_q + BALL_SIZE >= PAD_R_X) &&
            (ball_y_q + BALL_SIZE > pad_r_y) && (ball_y_q < pad_r_y + PAD_H);

    x_dir_d       = x_dir_q;
    miss          = 1'b0;
    miss_r_scores = 1'b0;
    if (!x_dir_q) begin
      if (hit_l) begin
        x_dir_d = 1'b1;
      end else if (ball_x_q < BALL_STEP) begin
        miss          = 1'b1;
        miss_r_scores = 1'b1;
      end
    end else begin
      if (hit_r) begin
        x_dir_d = 1'b0;
      end else if (ball_x_q >= H_VIS - BALL_SIZE) begin
        miss = 1'b1;
      end
    end

    ball_x_d  = x_dir_d ? ball_x_q + BALL_STEP : ball_x_q - BALL_STEP;
    ball_y_d  = y_dir_d ? ball_y_q + BALL_STEP : ball_y_q - BALL_STEP;
    score_inc = (scorer_r_q ? score_r_q : score_l_q) + 4'd1;
  end

  // Game phase FSM with ball, score and visibility registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= BALL_X0;
      ball_y_q    <= BALL_Y0;
      x_dir_q     <= 1'b1;
      y_dir_q     <= 1'b1;
      serve_cnt_q <= '0;
      scorer_r_q  <= 1'b0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      visible_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAME_OVER: begin
          if (start_i) begin
            score_l_q   <= '0;
            score_r_q   <= '0;
            ball_x_q    <= BALL_X0;
            ball_y_q    <= BALL_Y0;
            x_dir_q     <= 1'b1;
            y_dir_q     <= 1'b1;
            serve_cnt_q <= SERVE_FRAMES;
            state_q     <= ST_SERVE;
            visible_q   <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        ST_SERVE: begin
          if (frame_tick_i) begin
            serve_cnt_q <= serve_cnt_q - 6'd1;
            if (serve_cnt_q == 6'd1) state_q <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (frame_tick_i) begin
            x_dir_q <= x_dir_d;
            y_dir_q <= y_dir_d;
            if (miss) begin
              state_q    <= ST_POINT;
              scorer_r_q <= miss_r_scores;
              visible_q  <= 1'b0;
            end else begin
              ball_x_q <= ball_x_d;
              ball_y_q <= ball_y_d;
            end
          end
        end
        ST_POINT: begin
          if (scorer_r_q) score_r_q <= score_inc;
          else            score_l_q <= score_inc;
          if (score_inc == WIN_SCORE) begin
            state_q     <= ST_GAME_OVER;
            game_over_q <= 1'b1;
          end else begin
            ball_x_q    <= BALL_X0;
            ball_y_q    <= BALL_Y0;
            x_dir_q     <= ~scorer_r_q;
            serve_cnt_q <= SERVE_FRAMES;
            state_q     <= ST_SERVE;
            visible_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ball_x_o       = ball_x_q;
  assign ball_y_o       = ball_y_q;
  assign pad_l_y_o      = pad_l_y;
  assign pad_r_y_o      = pad_r_y;
  assign score_l_o      = score_l_q;
  assign score_r_o      = score_r_q;
  assign ball_visible_o = visible_q;
  assign game_over_o    = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - scoreboard bench for pong_game_ctrl
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0, start = 1'b0;
  logic up_l = 1'b0, dn_l = 1'b0, up_r = 1'b0, dn_r = 1'b0;
  logic [9:0] ball_x, ball_y, pad_l_y, pad_r_y;
  logic [3:0] score_l, score_r;
  logic ball_visible, game_over;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .frame_tick_i   (frame_tick),
    .start_i        (start),
    .up_l_i         (up_l),
    .dn_l_i         (dn_l),
    .up_r_i         (up_r),
    .dn_r_i         (dn_r),
    .ball_x_o       (ball_x),
    .ball_y_o       (ball_y),
    .pad_l_y_o      (pad_l_y),
    .pad_r_y_o      (pad_r_y),
    .score_l_o      (score_l),
    .score_r_o      (score_r),
    .ball_visible_o (ball_visible),
    .game_over_o    (game_over)
  );

  typedef struct packed {
    logic [9:0] bx, by, pl, pr;
    logic [3:0] sl, sr;
    logic       vis, go;
  } obs_t;

  obs_t sb[$];

  // Reference game model: 0 idle, 1 serve, 2 play, 3 game over
  int m_st, bx, by, xd, yd, pl, pr, sl, sr, cnt;
  bit ev_hit_l, ev_bot, ev_point;

  task automatic model_reset();
    m_st = 0; bx = 310; by = 230; xd = 1; yd = 1;
    pl = 200; pr = 200; sl = 0; sr = 0; cnt = 0;
  endtask

  function automatic int pad_next(int y, bit u, bit d);
    if (u && !d) return (y - 4 < 6) ? 6 : y - 4;
    if (d && !u) return (y + 4 > 394) ? 394 : y + 4;
    return y;
  endfunction

  task automatic model_step(input bit st, input bit tk, input bit ul, input bit dl,
                            input bit ur, input bit dr);
    bit miss, rsc;
    int opl, opr;
    ev_hit_l = 0; ev_bot = 0; ev_point = 0;
    miss = 0; rsc = 0;
    if ((m_st == 0 || m_st == 3) && st) begin
      sl = 0; sr = 0; bx = 310; by = 230; xd = 1; yd = 1; cnt = 60; m_st = 1;
      return;
    end
    if (!tk) return;
    opl = pl; opr = pr;
    if (m_st == 1 || m_st == 2) begin
      pl = pad_next(pl, ul, dl);
      pr = pad_next(pr, ur, dr);
    end
    if (m_st == 1) begin
      cnt = cnt - 1;
      if (cnt == 0) m_st = 2;
    end else if (m_st == 2) begin
      if (yd == 0 && by <= 7) yd = 1;
      if (yd == 1 && by + 20 >= 473) begin yd = 0; ev_bot = 1; end
      if (xd == 0) begin
        if (bx <= 15 && by + 20 > opl && by < opl + 80) begin xd = 1; ev_hit_l = 1; end
        else if (bx < 1) begin miss = 1; rsc = 1; end
      end else begin
        if (bx + 20 >= 625 && by + 20 > opr && by < opr + 80) xd = 0;
        else if (bx >= 620) begin miss = 1; rsc = 0; end
      end
      if (!miss) begin
        bx = bx + (xd ? 1 : -1);
        by = by + (yd ? 1 : -1);
      end else begin
        ev_point = 1;
        if (rsc) sr = sr + 1; else sl = sl + 1;
        if ((rsc ? sr : sl) == 9) m_st = 3;
        else begin bx = 310; by = 230; xd = rsc ? 0 : 1; cnt = 60; m_st = 1; end
      end
    end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.bx = 10'(bx); o.by = 10'(by); o.pl = 10'(pl); o.pr = 10'(pr);
    o.sl = 4'(sl); o.sr = 4'(sr);
    o.vis = (m_st == 1 || m_st == 2);
    o.go = (m_st == 3);
    return o;
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o.bx = 10'd310; o.by = 10'd230; o.pl = 10'd200; o.pr = 10'd200;
    o.sl = 4'd0; o.sr = 4'd0; o.vis = 1'b0; o.go = 1'b0;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.bx = ball_x; o.by = ball_y; o.pl = pad_l_y; o.pr = pad_r_y;
    o.sl = score_l; o.sr = score_r; o.vis = ball_visible; o.go = game_over;
    return o;
  endfunction

  // {up, dn}: chase keeps the paddle centred on the ball, otherwise it runs away
  function automatic logic [1:0] steer(int pad, int ball, bit chase);
    int pc, bc;
    pc = pad + 40;
    bc = ball + 10;
    if (chase) return (pc < bc) ? 2'b01 : ((pc > bc) ? 2'b10 : 2'b00);
    return (pc < bc) ? 2'b10 : 2'b01;
  endfunction

  // One stimulus cycle: push expected outputs, then pop and compare once settled
  task automatic step(input bit st, input bit tk, input bit ul, input bit dl,
                      input bit ur, input bit dr);
    obs_t got, exp;
    @(posedge clk); #1;
    start = st; frame_tick = tk; up_l = ul; dn_l = dl; up_r = ur; dn_r = dr;
    model_step(st, tk, ul, dl, ur, dr);
    sb.push_back(model_obs());
    @(posedge clk); #1;
    start = 0; frame_tick = 0; up_l = 0; dn_l = 0; up_r = 0; dn_r = 0;
    @(posedge clk); #1;
    got = dut_obs();
    exp = sb.pop_front();
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL step got bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d vis=%0b go=%0b exp bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d vis=%0b go=%0b",
               got.bx, got.by, got.pl, got.pr, got.sl, got.sr, got.vis, got.go,
               exp.bx, exp.by, exp.pl, exp.pr, exp.sl, exp.sr, exp.vis, exp.go);
    end
  endtask

  task automatic test_reset();
    obs_t got;
    rst_n = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    got = dut_obs();
    total++;
    if (got !== reset_obs()) begin
      bad++;
      $display("FAIL reset_hold got bx=%0d by=%0d pl=%0d vis=%0b go=%0b", got.bx, got.by, got.pl, got.vis, got.go);
    end
    rst_n = 1;
    @(posedge clk); #1;
    got = dut_obs();
    total++;
    if (got !== reset_obs()) begin
      bad++;
      $display("FAIL reset_release got bx=%0d by=%0d pl=%0d vis=%0b go=%0b", got.bx, got.by, got.pl, got.vis, got.go);
    end
  endtask

  task automatic test_serve();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 1, 0, 0, 0, 0);
    total++;
    if (ball_visible !== 1'b1 || ball_x !== 10'd310 || ball_y !== 10'd230) begin
      bad++;
      $display("FAIL serve_end got vis=%0b ball=(%0d,%0d) exp vis=1 ball=(310,230)", ball_visible, ball_x, ball_y);
    end
    step(0, 1, 0, 0, 0, 0);
    total++;
    if (ball_x !== 10'd311 || ball_y !== 10'd231) begin
      bad++;
      $display("FAIL first_move got (%0d,%0d) exp (311,231)", ball_x, ball_y);
    end
  endtask

  task automatic test_rally();
    logic [1:0] a, b;
    bit seen_bot, seen_hit;
    seen_bot = 0; seen_hit = 0;
    for (int i = 0; i < 3000 && !seen_hit; i++) begin
      a = steer(pl, by, 1);
      b = steer(pr, by, 1);
      step(0, 1, a[1], a[0], b[1], b[0]);
      if (ev_bot && !seen_bot) begin
        seen_bot = 1;
        total++;
        if (ball_y !== 10'd452) begin
          bad++;
          $display("FAIL bottom_bounce got ball_y=%0d exp 452", ball_y);
        end
      end
      if (ev_hit_l) begin
        seen_hit = 1;
        total++;
        if (ball_x !== 10'd16 || score_l !== 4'd0 || score_r !== 4'd0) begin
          bad++;
          $display("FAIL left_hit got x=%0d sl=%0d sr=%0d exp x=16 sl=0 sr=0", ball_x, score_l, score_r);
        end
      end
    end
    if (!seen_hit) begin
      total++; bad++;
      $display("FAIL rally_timeout got no left hit exp one");
    end
  endtask

  task automatic test_win();
    logic [1:0] a, b;
    int pts;
    pts = 0;
    for (int i = 0; i < 12000 && m_st != 3; i++) begin
      a = steer(pl, by, 1);
      b = steer(pr, by, 0);
      step(0, 1, a[1], a[0], b[1], b[0]);
      if (ev_point) begin
        pts++;
        total++;
        if (score_l !== 4'(pts) || score_r !== 4'd0) begin
          bad++;
          $display("FAIL left_point got sl=%0d sr=%0d exp sl=%0d sr=0", score_l, score_r, pts);
        end
        if (m_st == 1) begin
          total++;
          if (ball_x !== 10'd310 || ball_y !== 10'd230) begin
            bad++;
            $display("FAIL recentre got (%0d,%0d) exp (310,230)", ball_x, ball_y);
          end
        end
      end
    end
    total++;
    if (game_over !== 1'b1 || ball_visible !== 1'b0 || score_l !== 4'd9) begin
      bad++;
      $display("FAIL game_over got go=%0b vis=%0b sl=%0d exp go=1 vis=0 sl=9", game_over, ball_visible, score_l);
    end
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    total++;
    if (game_over !== 1'b1 || score_l !== 4'd9) begin
      bad++;
      $display("FAIL over_hold got go=%0b sl=%0d exp go=1 sl=9", game_over, score_l);
    end
    step(1, 1, 0, 0, 0, 0);
    total++;
    if (score_l !== 4'd0 || score_r !== 4'd0 || ball_visible !== 1'b1 || game_over !== 1'b0) begin
      bad++;
      $display("FAIL restart got sl=%0d sr=%0d vis=%0b go=%0b exp 0 0 1 0", score_l, score_r, ball_visible, game_over);
    end
  endtask

  task automatic test_paddles();
    int p0;
    p0 = pl;
    for (int i = 0; i < 10; i++) step(0, 1, 1, 1, 0, 0);
    total++;
    if (pad_l_y !== 10'(p0)) begin
      bad++;
      $display("FAIL pad_both got %0d exp %0d", pad_l_y, p0);
    end
    for (int i = 0; i < 100; i++) step(0, 1, 1, 0, 0, 0);
    total++;
    if (pad_l_y !== 10'd6) begin
      bad++;
      $display("FAIL pad_sat_top got %0d exp 6", pad_l_y);
    end
  endtask

  task automatic test_left_miss();
    logic [1:0] a, b;
    bit scored;
    scored = 0;
    for (int i = 0; i < 4000 && !scored; i++) begin
      a = steer(pl, by, 0);
      b = steer(pr, by, 1);
      step(0, 1, a[1], a[0], b[1], b[0]);
      if (ev_point) begin
        scored = 1;
        total++;
        if (score_r !== 4'd1 || score_l !== 4'd0 || ball_x !== 10'd310 || ball_y !== 10'd230) begin
          bad++;
          $display("FAIL left_miss got sr=%0d sl=%0d ball=(%0d,%0d) exp sr=1 sl=0 ball=(310,230)",
                   score_r, score_l, ball_x, ball_y);
        end
      end
    end
    if (!scored) begin
      total++; bad++;
      $display("FAIL left_miss_timeout got no point exp one");
    end
    for (int i = 0; i < 100 && m_st == 1; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    total++;
    if (ball_x !== 10'd309) begin
      bad++;
      $display("FAIL serve_left got ball_x=%0d exp 309", ball_x);
    end
  endtask

  task automatic test_reset_mid_play();
    obs_t got;
    for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 1, 0);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    got = dut_obs();
    total++;
    if (got !== reset_obs()) begin
      bad++;
      $display("FAIL reset_mid got bx=%0d by=%0d pl=%0d pr=%0d sl=%0d sr=%0d vis=%0b go=%0b",
               got.bx, got.by, got.pl, got.pr, got.sl, got.sr, got.vis, got.go);
    end
    model_reset();
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1;
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_serve();
    test_rally();
    test_win();
    test_paddles();
    test_left_miss();
    test_reset_mid_play();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
